// File: rtl/line_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : line_mem_arbiter
// Brief    : Two-port round-robin arbiter in front of a line-wide backing
//            store. The store serves I-cache (port 0) and D-cache (port 1)
//            line reads and writes after a fixed latency.
// Revision : 1.0 - initial release
// ============================================================================
module line_mem_arbiter #(
    parameter int LINEWORDS   = 8,
    parameter int WORDBITS    = 32,
    parameter int ADDRESSBITS = 32,
    parameter int MEMLINES    = 4096,
    parameter int LATENCY     = 4
) (
    input  logic                            CLK,
    input  logic                            RESET,
    input  logic                            p0_read,
    input  logic                            p0_write,
    input  logic [ADDRESSBITS-1:0]          p0_address,
    input  logic [LINEWORDS*WORDBITS-1:0]   p0_data_in,
    output logic [LINEWORDS*WORDBITS-1:0]   p0_data_out,
    output logic                            p0_accepted,
    input  logic                            p1_read,
    input  logic                            p1_write,
    input  logic [ADDRESSBITS-1:0]          p1_address,
    input  logic [LINEWORDS*WORDBITS-1:0]   p1_data_in,
    output logic [LINEWORDS*WORDBITS-1:0]   p1_data_out,
    output logic                            p1_accepted,
    output logic                            busy
);

    localparam int LINEBITS = LINEWORDS * WORDBITS;
    localparam int BYTEBITS = $clog2(LINEBITS / 8);
    localparam int IDXBITS  = $clog2(MEMLINES);
    localparam int CNTBITS  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [CNTBITS-1:0]     count_q, count_d;
    logic                   last_grant_q, last_grant_d;
    logic                   gnt_q, gnt_d;
    logic                   wr_q, wr_d;
    logic [IDXBITS-1:0]     index_q, index_d;
    logic [LINEBITS-1:0]    wdata_q, wdata_d;
    logic [LINEBITS-1:0]    dout0_q, dout0_d;
    logic [LINEBITS-1:0]    dout1_q, dout1_d;
    logic                   acc0_q, acc0_d;
    logic                   acc1_q, acc1_d;

    logic [LINEBITS-1:0]    mem_q [MEMLINES];

    logic                   w_req0;
    logic                   w_req1;
    logic                   w_gnt_req;
    logic                   w_grant;
    logic                   w_mem_we;
    logic                   w_unused_addr;

    assign w_req0    = p0_read | p0_write;
    assign w_req1    = p1_read | p1_write;
    assign w_gnt_req = gnt_q ? w_req1 : w_req0;

    // Only the line-index field of each address matters; the rest is folded here.
    assign w_unused_addr = ^{p0_address, p1_address};

    // State and datapath registers; the storage array is intentionally not reset.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q      <= S_IDLE;
            count_q      <= '0;
            last_grant_q <= 1'b1;
            gnt_q        <= 1'b0;
            wr_q         <= 1'b0;
            index_q      <= '0;
            wdata_q      <= '0;
            dout0_q      <= '0;
            dout1_q      <= '0;
            acc0_q       <= 1'b0;
            acc1_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            last_grant_q <= last_grant_d;
            gnt_q        <= gnt_d;
            wr_q         <= wr_d;
            index_q      <= index_d;
            wdata_q      <= wdata_d;
            dout0_q      <= dout0_d;
            dout1_q      <= dout1_d;
            acc0_q       <= acc0_d;
            acc1_q       <= acc1_d;
        end
    end

    // Storage array write port, fired on the final BUSY cycle of a write.
    always_ff @(posedge CLK) begin
        if (w_mem_we) begin
            mem_q[index_q] <= wdata_q;
        end
    end

    // Arbitration, latency countdown and response sequencing.
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        last_grant_d = last_grant_q;
        gnt_d        = gnt_q;
        wr_d         = wr_q;
        index_d      = index_q;
        wdata_d      = wdata_q;
        dout0_d      = dout0_q;
        dout1_d      = dout1_q;
        acc0_d       = 1'b0;
        acc1_d       = 1'b0;
        w_mem_we     = 1'b0;
        w_grant      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (w_req0 || w_req1) begin
                    // Contention goes to the port not served last; every grant
                    // updates the round-robin pointer.
                    w_grant      = (w_req0 && w_req1) ? ~last_grant_q : w_req1;
                    gnt_d        = w_grant;
                    last_grant_d = w_grant;
                    // write wins when read and write are both raised
                    wr_d         = w_grant ? p1_write : p0_write;
                    index_d      = w_grant ? p1_address[BYTEBITS +: IDXBITS]
                                           : p0_address[BYTEBITS +: IDXBITS];
                    wdata_d      = w_grant ? p1_data_in : p0_data_in;
                    count_d      = CNTBITS'(LATENCY - 1);
                    state_d      = S_BUSY;
                end
            end
            S_BUSY: begin
                if (!w_gnt_req) begin
                    state_d = S_IDLE;
                end else if (count_q != '0) begin
                    count_d = count_q - CNTBITS'(1);
                end else begin
                    if (wr_q) begin
                        // gated so an edge that lands while reset is held cannot write
                        w_mem_we = RESET;
                    end else if (gnt_q) begin
                        dout1_d = mem_q[index_q];
                    end else begin
                        dout0_d = mem_q[index_q];
                    end
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                acc0_d  = ~gnt_q;
                acc1_d  = gnt_q;
                state_d = S_GAP;
            end
            S_GAP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign p0_data_out = dout0_q;
    assign p1_data_out = dout1_q;
    assign p0_accepted = acc0_q;
    assign p1_accepted = acc1_q;
    assign busy        = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_line_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_line_mem_arbiter
// Brief    : Randomised scoreboard bench for line_mem_arbiter. Expected
//            responses are queued at issue time from a transaction-level model;
//            an independent monitor checks each accepted pulse.
// Revision : 1.0 - initial release
// ============================================================================
module tb_line_mem_arbiter;

    localparam int LW  = 8;
    localparam int WB  = 32;
    localparam int AB  = 32;
    localparam int ML  = 4096;
    localparam int LAT = 4;
    localparam int LB  = LW * WB;

    logic          CLK = 1'b0;
    logic          RESET = 1'b0;
    logic          p0_read = 1'b0, p0_write = 1'b0;
    logic [AB-1:0] p0_address = '0;
    logic [LB-1:0] p0_data_in = '0;
    logic [LB-1:0] p0_data_out;
    logic          p0_accepted;
    logic          p1_read = 1'b0, p1_write = 1'b0;
    logic [AB-1:0] p1_address = '0;
    logic [LB-1:0] p1_data_in = '0;
    logic [LB-1:0] p1_data_out;
    logic          p1_accepted;
    logic          busy;

    line_mem_arbiter #(
        .LINEWORDS(LW), .WORDBITS(WB), .ADDRESSBITS(AB), .MEMLINES(ML), .LATENCY(LAT)
    ) dut (
        .CLK(CLK), .RESET(RESET),
        .p0_read(p0_read), .p0_write(p0_write), .p0_address(p0_address),
        .p0_data_in(p0_data_in), .p0_data_out(p0_data_out), .p0_accepted(p0_accepted),
        .p1_read(p1_read), .p1_write(p1_write), .p1_address(p1_address),
        .p1_data_in(p1_data_in), .p1_data_out(p1_data_out), .p1_accepted(p1_accepted),
        .busy(busy)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // op: 0 none, 1 read, 2 write, 3 read+write (behaves as write)
    typedef struct {
        int            op;
        logic [AB-1:0] addr;
        logic [LB-1:0] data;
    } req_t;

    typedef struct {
        int            port;
        int            cyc;
        logic [LB-1:0] dout;
    } exp_t;

    exp_t          sb[$];
    int            checks = 0;
    int            failures = 0;

    // Reference model: line storage, round-robin pointer, per-port read data.
    logic [LB-1:0] mdl_mem [ML];
    int            mdl_last = 1;
    logic [LB-1:0] mdl_dout [2];

    task automatic chk(input string name, input logic [LB-1:0] act, input logic [LB-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    function automatic logic [LB-1:0] rnd_line();
        logic [LB-1:0] l;
        for (int w = 0; w < LW; w++) l[w*WB +: WB] = $urandom();
        return l;
    endfunction

    function automatic req_t rnd_req();
        req_t r;
        int   idx;
        idx     = int'($urandom_range(0, 7));
        r.op    = int'($urandom_range(0, 3));
        r.addr  = $urandom();           // high bits random: exercises aliasing
        r.addr[16:5] = 12'(idx);
        r.data  = rnd_line();
        return r;
    endfunction

    task automatic mdl_service(input int p, input req_t r, output logic [LB-1:0] dout);
        int idx;
        idx = int'((r.addr / (LB / 8)) % ML);
        if (r.op >= 2) mdl_mem[idx] = r.data;
        else           mdl_dout[p]  = mdl_mem[idx];
        dout = mdl_dout[p];
    endtask

    task automatic set_req(input int p, input req_t r);
        if (p == 0) begin
            p0_read = (r.op == 1 || r.op == 3); p0_write = (r.op >= 2);
            p0_address = r.addr; p0_data_in = r.data;
        end else begin
            p1_read = (r.op == 1 || r.op == 3); p1_write = (r.op >= 2);
            p1_address = r.addr; p1_data_in = r.data;
        end
    endtask

    task automatic clr_req(input int p);
        if (p == 0) begin p0_read = 1'b0; p0_write = 1'b0; end
        else        begin p1_read = 1'b0; p1_write = 1'b0; end
    endtask

    // Hold a port's request until its pulse; optionally disturb address/data after grant.
    task automatic run_port(input int p, input int hold, input bit scramble);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge CLK);
            if (i == 0 && scramble) begin
                if (p == 0) begin p0_address = $urandom(); p0_data_in = rnd_line(); end
                else        begin p1_address = $urandom(); p1_data_in = rnd_line(); end
            end
            if ((p == 0) ? p0_accepted : p1_accepted) seen = 1'b1;
        end
        if (!seen) begin
            checks++; failures++;
            $display("FAIL port%0d_timeout: got no accepted pulse, expected one", p);
        end else begin
            repeat (hold) @(negedge CLK);
        end
        clr_req(p);
    endtask

    // Raise up to two requests on the same edge; the model predicts order, timing and data.
    task automatic do_pair(input req_t r0, input req_t r1, input bit hold_first);
        bit   have0, have1;
        int   e0, first, second, hold;
        exp_t e;
        have0 = (r0.op != 0);
        have1 = (r1.op != 0);
        if (!have0 && !have1) return;
        @(negedge CLK);
        e0     = cyc + 1;
        first  = (have0 && have1) ? ((mdl_last == 1) ? 0 : 1) : (have1 ? 1 : 0);
        second = 1 - first;
        hold   = (hold_first && have0 && have1) ? 2 : 0;
        mdl_last = first;
        e.port = first;
        e.cyc  = e0 + LAT + 1;
        mdl_service(first, (first == 1) ? r1 : r0, e.dout);
        sb.push_back(e);
        if (have0 && have1) begin
            mdl_last = second;
            e.port = second;
            e.cyc  = e0 + 2 * LAT + 4;   // granted in the IDLE after the first GAP
            mdl_service(second, (second == 1) ? r1 : r0, e.dout);
            sb.push_back(e);
        end
        if (have0) set_req(0, r0);
        if (have1) set_req(1, r1);
        fork
            begin if (have0) run_port(0, (first == 0) ? hold : 0, first == 0); end
            begin if (have1) run_port(1, (first == 1) ? hold : 0, first == 1); end
        join
        repeat (3) @(negedge CLK);
        chk1("idle_busy", busy, 1'b0);
    endtask

    // Monitor: every accepted pulse pops one expected response.
    initial begin : monitor
        int   p;
        exp_t e;
        forever begin
            @(negedge CLK);
            if (p0_accepted && p1_accepted) begin
                checks++; failures++;
                $display("FAIL both_accepted: got both ports high, expected at most one");
            end else if (p0_accepted || p1_accepted) begin
                p = p1_accepted ? 1 : 0;
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_pulse: got pulse on port %0d at cycle %0d, expected none", p, cyc);
                end else begin
                    e = sb.pop_front();
                    if (e.port != p || e.cyc != cyc) begin
                        failures++;
                        $display("FAIL sb_order: got port %0d cycle %0d, expected port %0d cycle %0d",
                                 p, cyc, e.port, e.cyc);
                    end
                    chk("sb_data_out", (p == 1) ? p1_data_out : p0_data_out, e.dout);
                    chk1("sb_busy", busy, 1'b1);
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        req_t          a, b, none;
        logic [LB-1:0] tp;
        none.op = 0; none.addr = '0; none.data = '0;
        mdl_dout[0] = '0; mdl_dout[1] = '0;

        RESET = 1'b0;
        repeat (3) @(negedge CLK);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_p0_acc", p0_accepted, 1'b0);
        chk1("rst_p1_acc", p1_accepted, 1'b0);
        chk("rst_p0_dout", p0_data_out, '0);
        chk("rst_p1_dout", p1_data_out, '0);
        RESET = 1'b1;

        // Write then read back one line on port 1.
        tp = 256'h1111111122222222333333334444444455555555666666667777777788888888;
        a = none; a.op = 2; a.addr = 32'h0000_0040; a.data = tp;
        do_pair(none, a, 1'b0);
        a.op = 1;
        do_pair(none, a, 1'b0);

        // Simultaneous reads: port 0 wins after a port 1 grant.
        b = none; b.op = 1; b.addr = 32'h0000_0040;
        do_pair(b, a, 1'b0);

        // Fill the lines the random phase uses.
        for (int i = 0; i < 8; i++) begin
            a = none; a.op = 2; a.addr = 32'(i) << 5; a.data = rnd_line();
            if (i % 2 == 1) do_pair(none, a, 1'b0);
            else            do_pair(a, none, 1'b0);
        end

        // First-served port keeps its request up through GAP; other port must follow.
        a = none; a.op = 1; a.addr = 32'h0000_0060;
        b = none; b.op = 1; b.addr = 32'h0000_00A0;
        do_pair(a, b, 1'b1);

        // Abort: p1 write to 0x20 dropped after two BUSY cycles.
        a = none; a.op = 2; a.addr = 32'h0000_0020; a.data = rnd_line();
        @(negedge CLK);
        set_req(1, a);
        mdl_last = 1;
        repeat (3) @(negedge CLK);
        clr_req(1);
        repeat (4) @(negedge CLK);
        chk1("abort_busy", busy, 1'b0);
        a.op = 1;
        do_pair(a, none, 1'b0);

        // Reset in the middle of a write: outputs clear at once, no array update.
        a = none; a.op = 2; a.addr = 32'h0000_0060; a.data = rnd_line();
        @(negedge CLK);
        set_req(1, a);
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        #1;
        chk1("midrst_busy", busy, 1'b0);
        chk1("midrst_p0_acc", p0_accepted, 1'b0);
        chk1("midrst_p1_acc", p1_accepted, 1'b0);
        chk("midrst_p0_dout", p0_data_out, '0);
        chk("midrst_p1_dout", p1_data_out, '0);
        clr_req(1);
        @(negedge CLK);
        RESET = 1'b1;
        mdl_last = 1; mdl_dout[0] = '0; mdl_dout[1] = '0;
        a.op = 1;
        do_pair(a, none, 1'b0);

        // Line index MEMLINES+1 aliases onto index 1.
        a = none; a.op = 2; a.addr = 32'(ML + 1) << 5; a.data = rnd_line();
        do_pair(a, none, 1'b0);
        a = none; a.op = 1; a.addr = 32'h0000_0020;
        do_pair(none, a, 1'b0);

        // Read and write together on port 0: write happens, data_out untouched.
        a = none; a.op = 3; a.addr = 32'h0000_00C0; a.data = rnd_line();
        do_pair(a, none, 1'b0);
        a.op = 1;
        do_pair(none, a, 1'b0);

        // Random traffic.
        for (int i = 0; i < 40; i++) begin
            a = rnd_req();
            b = rnd_req();
            do_pair(a, b, 1'($urandom_range(0, 1)));
        end

        repeat (5) @(negedge CLK);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_drain: got %0d outstanding responses, expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/line_mem_arbiter.md
Name: line_mem_arbiter

Overview:
- Shared backing-memory stage directly downstream of the instruction and data caches.
- Accepts whole-line read and write requests from two cache ports and arbitrates between them round-robin.
- Services each granted request against an internal line-wide storage array after a fixed, parameterised latency.
- Port signalling matches the cache miss interface: the cache drives read/write/address/data; this block returns line data plus a one-cycle accepted pulse.

Parameters:
- LINEWORDS, 8, words per line.
- WORDBITS, 32, bits per word. LINEBITS = LINEWORDS*WORDBITS.
- ADDRESSBITS, 32, request address width.
- MEMLINES, 4096, lines of storage; power of two.
- LATENCY, 4, cycles from grant to accepted pulse; must be ≥1.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RESET  in  1  asynchronous active-low reset.
- p0_read  in  1  port 0 (I-cache) line read request; level, held until accepted.
- p0_write  in  1  port 0 line write request; level, held until accepted.
- p0_address  in  ADDRESSBITS  port 0 line address; byte offset bits ignored.
- p0_data_in  in  LINEBITS  port 0 write line; word 0 in MSBs.
- p0_data_out  out  LINEBITS  port 0 read line.
- p0_accepted  out  1  port 0 one-cycle completion pulse.
- p1_read, p1_write, p1_address, p1_data_in, p1_data_out, p1_accepted: port 1 (D-cache), identical to port 0.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Addressing: BYTEBITS = log2(LINEBITS/8). Line index = address[BYTEBITS+log2(MEMLINES)-1 : BYTEBITS]. Higher address bits are ignored, so addresses alias modulo MEMLINES lines. Lines are stored verbatim, with no byte swapping.
- Reset (RESET=0, async):
  - state=IDLE; count=0; last_grant=1.
  - p0/p1_data_out=0; p0/p1_accepted=0; busy=0.
  - Storage array is not cleared. Reset mid-operation aborts the operation with no array write and no accepted pulse.
- Request validity: a port requests when read|write. If both read and write are high, the request is treated as a write and the read is ignored.
- FSM states: IDLE, BUSY, RESP, GAP.
  - IDLE: if any port is requesting, grant it and latch its op, index and write data. On simultaneous requests, grant the port != last_grant, then set last_grant = granted port. Go to BUSY with count=LATENCY-1.
  - BUSY:
    - If the granted port's request drops, abort: go to IDLE, no write, no pulse.
    - Else if count≠0, decrement count.
    - Else perform the op and go to RESP. Write: array[index] <= latched data. Read: granted port's data_out <= array[index].
  - RESP: granted port's accepted=1 for exactly this cycle. Go to GAP.
  - GAP: one idle cycle, so a request still high from the just-accepted port is not re-granted. Go to IDLE.
- Latency: request sampled at posedge E0 → accepted high from posedge E0+LATENCY+1 to E0+LATENCY+2. For reads, data_out is valid from the same edge as accepted and holds until that port's next read completes.
- Address and data are latched at grant; later changes while BUSY are ignored, except that dropping the request aborts.
- The ungranted port waits; its request is not lost and is granted in the IDLE following GAP.
- accepted is never high on both ports in the same cycle.

Test Plan:
- Reset, then p1_write to address 0x00000040 with data 0x11111111_22222222_..._88888888 (LATENCY=4) → p1_accepted is a single pulse 5 edges after sampling; busy=1 during. Then p1_read of 0x00000040 → p1_data_out equals the written line, valid together with the pulse.
- p0_read and p1_read raised on the same edge after reset → p0 is served first (last_grant=1). p1 is granted in the IDLE after GAP. Pulses are non-overlapping and separated by ≥1 idle cycle.
- p0 holds p0_read high for 2 cycles after its pulse → no second grant to p0 during GAP. A pending p1 request is granted next.
- p1_write to 0x00000020 dropped after 2 BUSY cycles → no p1_accepted pulse. A later read of 0x00000020 returns the prior contents, FSM back in IDLE.
- RESET asserted during BUSY of a write → all outputs 0 immediately, no array write. Write to line index MEMLINES+1 then read index 1 → aliased data returned.
- Simultaneous read=1 and write=1 on p0 → write performed; p0_data_out unchanged.
